// File: rtl/pp_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package pp_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    localparam int MEM_ADDR_WIDTH_DEF = 30;
    // Wide enough for the largest supported latency of 7 cycles.
    localparam int CNT_W              = 3;

endpackage

// File: rtl/mem_arb_timer.sv
// Tracks the single outstanding memory access: busy countdown, owner, and
// whether a fetch response has been killed by a branch flush.
module mem_arb_timer
    import pp_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             grant_i,
    input  owner_e           grantOwner_i,
    input  logic             grantKill_i,
    input  logic             ifKill_i,
    output logic [CNT_W-1:0] cnt_o,
    output owner_e           owner_o,
    output logic             kill_o,
    output logic             capture_o,
    output logic             window_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           owner_q, owner_d;
    logic             kill_q, kill_d;

    always_comb begin
        cnt_d   = cnt_q;
        owner_d = owner_q;
        kill_d  = kill_q;
        if (grant_i) begin
            cnt_d   = CNT_W'(MEM_LATENCY);
            owner_d = grantOwner_i;
            kill_d  = grantKill_i;
        end else begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (ifKill_i && (owner_q == OWN_IF) && (cnt_q != '0)) begin
                kill_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q   <= '0;
            owner_q <= OWN_NONE;
            kill_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign owner_o   = owner_q;
    assign kill_o    = kill_q;
    // The last busy cycle both delivers read data and reopens arbitration.
    assign capture_o = (cnt_q == CNT_W'(1));
    assign window_o  = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// the data-memory stage, with a starvation guard for fetch.
module unified_mem_arbiter
    import pp_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
    parameter int MEM_LATENCY    = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      if_req,
    input  logic [MEM_ADDR_WIDTH-1:0] if_addr,
    input  logic                      if_kill,
    output logic                      if_gnt,
    output logic                      if_rsp_valid,
    output logic [DATA_WIDTH-1:0]     if_rsp_data,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [MEM_ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0]     dm_wr_data,
    output logic                      dm_gnt,
    output logic                      dm_rsp_valid,
    output logic [DATA_WIDTH-1:0]     dm_rsp_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wr_data,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    output logic                      stall_if,
    output logic                      stall_mem
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]    cnt;
    owner_e              owner;
    logic                kill, capture, window;
    logic                ifGnt, dmGnt;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                ownerWe_q, ownerWe_d;
    logic                ifRspValid_q, ifRspValid_d, dmRspValid_q, dmRspValid_d;
    logic [DATA_WIDTH-1:0] ifRspData_q, ifRspData_d, dmRspData_q, dmRspData_d;

    mem_arb_timer #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_timer (
        .clk         (clk),
        .rstb        (rstb),
        .grant_i     (ifGnt | dmGnt),
        .grantOwner_i(ifGnt ? OWN_IF : OWN_DM),
        .grantKill_i (ifGnt & if_kill),
        .ifKill_i    (if_kill),
        .cnt_o       (cnt),
        .owner_o     (owner),
        .kill_o      (kill),
        .capture_o   (capture),
        .window_o    (window)
    );

    // Data side wins contention unless fetch has lost STARVE_LIMIT times in a row.
    always_comb begin
        ifGnt = 1'b0;
        dmGnt = 1'b0;
        if (window) begin
            if (dm_req && if_req) begin
                if (starve_q == STARVE_W'(STARVE_LIMIT)) ifGnt = 1'b1;
                else                                     dmGnt = 1'b1;
            end else if (dm_req) begin
                dmGnt = 1'b1;
            end else if (if_req) begin
                ifGnt = 1'b1;
            end
        end
    end

    always_comb begin
        ifRspValid_d = 1'b0;
        dmRspValid_d = 1'b0;
        ifRspData_d  = ifRspData_q;
        dmRspData_d  = dmRspData_q;
        ownerWe_d    = ownerWe_q;
        starve_d     = starve_q;
        if (capture) begin
            if ((owner == OWN_IF) && !(kill || if_kill)) begin
                ifRspValid_d = 1'b1;
                ifRspData_d  = mem_rd_data;
            end
            if (owner == OWN_DM) begin
                dmRspValid_d = 1'b1;
                if (!ownerWe_q) dmRspData_d = mem_rd_data;
            end
        end
        if (dmGnt)      ownerWe_d = dm_we;
        else if (ifGnt) ownerWe_d = 1'b0;
        if (ifGnt) begin
            starve_d = '0;
        end else if (dmGnt && if_req && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            starve_q     <= '0;
            ownerWe_q    <= 1'b0;
            ifRspValid_q <= 1'b0;
            dmRspValid_q <= 1'b0;
            ifRspData_q  <= '0;
            dmRspData_q  <= '0;
        end else begin
            starve_q     <= starve_d;
            ownerWe_q    <= ownerWe_d;
            ifRspValid_q <= ifRspValid_d;
            dmRspValid_q <= dmRspValid_d;
            ifRspData_q  <= ifRspData_d;
            dmRspData_q  <= dmRspData_d;
        end
    end

    assign if_gnt       = ifGnt;
    assign dm_gnt       = dmGnt;
    assign if_rsp_valid = ifRspValid_q;
    assign if_rsp_data  = ifRspData_q;
    assign dm_rsp_valid = dmRspValid_q;
    assign dm_rsp_data  = dmRspData_q;

    // Memory port is held quiet while reset is asserted.
    assign mem_en      = rstb & (ifGnt | dmGnt);
    assign mem_we      = rstb & dmGnt & dm_we;
    assign mem_addr    = !rstb ? '0 : (dmGnt ? dm_addr : (ifGnt ? if_addr : '0));
    assign mem_wr_data = (rstb & dmGnt) ? dm_wr_data : '0;

    assign stall_if  = if_req & ~ifGnt;
    assign stall_mem = (dm_req & ~dmGnt) | ((owner == OWN_DM) && (cnt != '0));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a two-cycle latency memory model.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstb;
    logic        if_req, if_kill, if_gnt, if_rsp_valid;
    logic [29:0] if_addr;
    logic [31:0] if_rsp_data;
    logic        dm_req, dm_we, dm_gnt, dm_rsp_valid;
    logic [29:0] dm_addr;
    logic [31:0] dm_wr_data, dm_rsp_data;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic        stall_if, stall_mem;

    int checks   = 0;
    int failures = 0;

    unified_mem_arbiter #(
        .DATA_WIDTH    (32),
        .MEM_ADDR_WIDTH(30),
        .MEM_LATENCY   (2),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_kill     (if_kill),
        .if_gnt      (if_gnt),
        .if_rsp_valid(if_rsp_valid),
        .if_rsp_data (if_rsp_data),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wr_data  (dm_wr_data),
        .dm_gnt      (dm_gnt),
        .dm_rsp_valid(dm_rsp_valid),
        .dm_rsp_data (dm_rsp_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem)
    );

    always #5 clk = ~clk;

    // Memory contents: a few fixed words plus the most recent write.
    logic [31:0] rdStage1 = '0;
    logic [31:0] rdStage2 = '0;
    logic        wrSeen = 1'b0;
    logic [7:0]  lastWrAddr = '0;
    logic [31:0] lastWrData = '0;

    function automatic logic [31:0] baseData(input logic [7:0] a);
        case (a)
            8'h10:   return 32'h2402000A;
            8'h14:   return 32'h11112222;
            8'h18:   return 32'hCAFEF00D;
            8'h1C:   return 32'h55AA55AA;
            8'h40:   return 32'hDEADBEEF;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                wrSeen     <= 1'b1;
                lastWrAddr <= mem_addr[7:0];
                lastWrData <= mem_wr_data;
            end
            rdStage1 <= (wrSeen && (lastWrAddr == mem_addr[7:0])) ? lastWrData
                                                                   : baseData(mem_addr[7:0]);
        end
        rdStage2 <= rdStage1;
    end
    assign mem_rd_data = rdStage2;

    task automatic applyStimulus(input logic ifReq, input logic [29:0] ifAddr, input logic ifKill,
                                 input logic dmReq, input logic dmWe, input logic [29:0] dmAddr,
                                 input logic [31:0] dmWrData);
        if_req     = ifReq;
        if_addr    = ifAddr;
        if_kill    = ifKill;
        dm_req     = dmReq;
        dm_we      = dmWe;
        dm_addr    = dmAddr;
        dm_wr_data = dmWrData;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstb = 1'b0;
        idle();
        sample();
        checkOutput("reset_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        checkOutput("reset_dm_rsp_valid", 32'(dm_rsp_valid), 32'd0);
        checkOutput("reset_if_rsp_data", if_rsp_data, 32'h0);
        checkOutput("reset_dm_rsp_data", dm_rsp_data, 32'h0);
        checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset_stall_mem", 32'(stall_mem), 32'd0);
        advance();
        rstb = 1'b1;
        sample();
        advance();

        $display("[TB] IF-only read");
        applyStimulus(1'b1, 30'h10, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
        sample();
        checkOutput("t1_if_gnt", 32'(if_gnt), 32'd1);
        checkOutput("t1_mem_en", 32'(mem_en), 32'd1);
        checkOutput("t1_mem_we", 32'(mem_we), 32'd0);
        checkOutput("t1_mem_addr", 32'(mem_addr), 32'h10);
        checkOutput("t1_stall_if", 32'(stall_if), 32'd0);
        advance();
        idle();
        sample();
        checkOutput("t1_busy_if_gnt", 32'(if_gnt), 32'd0);
        checkOutput("t1_valid_early1", 32'(if_rsp_valid), 32'd0);
        advance();
        sample();
        checkOutput("t1_valid_early2", 32'(if_rsp_valid), 32'd0);
        advance();
        sample();
        checkOutput("t1_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        checkOutput("t1_if_rsp_data", if_rsp_data, 32'h2402000A);
        advance();
        sample();
        checkOutput("t1_valid_pulse_end", 32'(if_rsp_valid), 32'd0);
        advance();

        $display("[TB] IF and DM contention");
        applyStimulus(1'b1, 30'h14, 1'b0, 1'b1, 1'b0, 30'h40, 32'h0);
        sample();
        checkOutput("t2_dm_gnt", 32'(dm_gnt), 32'd1);
        checkOutput("t2_if_gnt_lose", 32'(if_gnt), 32'd0);
        checkOutput("t2_stall_if_T", 32'(stall_if), 32'd1);
        checkOutput("t2_stall_mem_T", 32'(stall_mem), 32'd0);
        checkOutput("t2_mem_addr_dm", 32'(mem_addr), 32'h40);
        advance();
        applyStimulus(1'b1, 30'h14, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
        sample();
        checkOutput("t2_if_gnt_T1", 32'(if_gnt), 32'd0);
        checkOutput("t2_stall_if_T1", 32'(stall_if), 32'd1);
        checkOutput("t2_stall_mem_T1", 32'(stall_mem), 32'd1);
        advance();
        sample();
        checkOutput("t2_if_gnt_T2", 32'(if_gnt), 32'd1);
        checkOutput("t2_stall_if_T2", 32'(stall_if), 32'd0);
        checkOutput("t2_mem_addr_if", 32'(mem_addr), 32'h14);
        advance();
        idle();
        sample();
        checkOutput("t2_dm_rsp_valid", 32'(dm_rsp_valid), 32'd1);
        checkOutput("t2_dm_rsp_data", dm_rsp_data, 32'hDEADBEEF);
        checkOutput("t2_stall_mem_T3", 32'(stall_mem), 32'd0);
        advance();
        sample();
        checkOutput("t2_dm_pulse_end", 32'(dm_rsp_valid), 32'd0);
        checkOutput("t2_if_valid_early", 32'(if_rsp_valid), 32'd0);
        advance();
        sample();
        checkOutput("t2_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        checkOutput("t2_if_rsp_data", if_rsp_data, 32'h11112222);
        advance();

        $display("[TB] starvation guard");
        applyStimulus(1'b1, 30'h18, 1'b0, 1'b1, 1'b0, 30'h40, 32'h0);
        for (int w = 0; w < 4; w++) begin
            sample();
            checkOutput($sformatf("t3_dm_gnt_w%0d", w), 32'(dm_gnt), 32'd1);
            checkOutput($sformatf("t3_if_gnt_w%0d", w), 32'(if_gnt), 32'd0);
            advance();
            sample();
            checkOutput($sformatf("t3_busy_w%0d", w), 32'(dm_gnt | if_gnt), 32'd0);
            advance();
        end
        sample();
        checkOutput("t3_if_forced", 32'(if_gnt), 32'd1);
        checkOutput("t3_dm_blocked", 32'(dm_gnt), 32'd0);
        checkOutput("t3_mem_addr_if", 32'(mem_addr), 32'h18);
        advance();
        applyStimulus(1'b1, 30'h1C, 1'b0, 1'b1, 1'b0, 30'h40, 32'h0);
        sample();
        advance();
        sample();
        checkOutput("t3_dm_after_clear", 32'(dm_gnt), 32'd1);
        checkOutput("t3_if_after_clear", 32'(if_gnt), 32'd0);
        advance();
        applyStimulus(1'b1, 30'h1C, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
        sample();
        checkOutput("t3_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        checkOutput("t3_if_rsp_data", if_rsp_data, 32'hCAFEF00D);
        advance();
        sample();
        checkOutput("t3_if_gnt_second", 32'(if_gnt), 32'd1);
        advance();
        idle();
        sample();
        checkOutput("t3_dm_rsp_valid", 32'(dm_rsp_valid), 32'd1);
        advance();
        advance();
        sample();
        checkOutput("t3_if_rsp_data2", if_rsp_data, 32'h55AA55AA);
        advance();

        $display("[TB] DM write");
        applyStimulus(1'b0, 30'h0, 1'b0, 1'b1, 1'b1, 30'h44, 32'h12345678);
        sample();
        checkOutput("t4_dm_gnt", 32'(dm_gnt), 32'd1);
        checkOutput("t4_mem_we", 32'(mem_we), 32'd1);
        checkOutput("t4_mem_wr_data", mem_wr_data, 32'h12345678);
        checkOutput("t4_mem_addr", 32'(mem_addr), 32'h44);
        advance();
        idle();
        sample();
        checkOutput("t4_mem_we_off", 32'(mem_we), 32'd0);
        checkOutput("t4_mem_en_off", 32'(mem_en), 32'd0);
        advance();
        advance();
        sample();
        checkOutput("t4_dm_rsp_valid", 32'(dm_rsp_valid), 32'd1);
        checkOutput("t4_dm_rsp_data_kept", dm_rsp_data, 32'hDEADBEEF);
        advance();
        applyStimulus(1'b0, 30'h0, 1'b0, 1'b1, 1'b0, 30'h44, 32'h0);
        sample();
        checkOutput("t4_readback_gnt", 32'(dm_gnt), 32'd1);
        advance();
        idle();
        advance();
        advance();
        sample();
        checkOutput("t4_readback_valid", 32'(dm_rsp_valid), 32'd1);
        checkOutput("t4_readback_data", dm_rsp_data, 32'h12345678);
        advance();

        $display("[TB] fetch kill");
        applyStimulus(1'b1, 30'h10, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
        sample();
        checkOutput("t5_if_gnt", 32'(if_gnt), 32'd1);
        advance();
        applyStimulus(1'b0, 30'h0, 1'b1, 1'b0, 1'b0, 30'h0, 32'h0);
        sample();
        advance();
        applyStimulus(1'b1, 30'h14, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
        sample();
        checkOutput("t5_next_gnt", 32'(if_gnt), 32'd1);
        advance();
        idle();
        sample();
        checkOutput("t5_killed_valid", 32'(if_rsp_valid), 32'd0);
        checkOutput("t5_killed_data", if_rsp_data, 32'h55AA55AA);
        advance();
        sample();
        checkOutput("t5_valid_early", 32'(if_rsp_valid), 32'd0);
        advance();
        sample();
        checkOutput("t5_after_kill_valid", 32'(if_rsp_valid), 32'd1);
        checkOutput("t5_after_kill_data", if_rsp_data, 32'h11112222);
        advance();

        $display("[TB] reset mid-access");
        applyStimulus(1'b0, 30'h0, 1'b0, 1'b1, 1'b0, 30'h40, 32'h0);
        sample();
        checkOutput("t6_dm_gnt", 32'(dm_gnt), 32'd1);
        advance();
        idle();
        rstb = 1'b0;
        sample();
        checkOutput("t6_rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("t6_rst_stall_mem", 32'(stall_mem), 32'd0);
        checkOutput("t6_rst_dm_rsp_data", dm_rsp_data, 32'h0);
        checkOutput("t6_rst_if_rsp_data", if_rsp_data, 32'h0);
        advance();
        rstb = 1'b1;
        applyStimulus(1'b1, 30'h10, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0);
        sample();
        checkOutput("t6_gnt_after_rst", 32'(if_gnt), 32'd1);
        checkOutput("t6_mem_en_after_rst", 32'(mem_en), 32'd1);
        advance();
        idle();
        sample();
        checkOutput("t6_no_dm_pulse1", 32'(dm_rsp_valid), 32'd0);
        advance();
        sample();
        checkOutput("t6_no_dm_pulse2", 32'(dm_rsp_valid), 32'd0);
        advance();
        sample();
        checkOutput("t6_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        checkOutput("t6_if_rsp_data", if_rsp_data, 32'h2402000A);
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port, fixed-latency unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. Arbitrates one access at a time with a starvation guard, tracks the single outstanding access, routes the read data back to its owner, and produces the stall signals that feed the PC/IF hold and MEM-stage hold logic.

## Interface
- DATA_WIDTH, 32, data word width
- MEM_ADDR_WIDTH, 30, word address width (byte address bits [31:2])
- MEM_LATENCY, 2, cycles from mem_en to valid mem_rd_data; legal range 1..7
- STARVE_LIMIT, 4, consecutive IF losses before IF is forced to win; legal range ≥1
- clk  in  1  clock, rising edge
- rstb  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; if_addr held stable until if_gnt
- if_addr  in  MEM_ADDR_WIDTH  fetch word address
- if_kill  in  1  discard the outstanding or same-cycle-granted fetch response (branch flush)
- if_gnt  out  1  fetch accepted this cycle
- if_rsp_valid  out  1  one-cycle pulse: if_rsp_data updated
- if_rsp_data  out  DATA_WIDTH  last fetch data, held
- dm_req, dm_we  in  1 each  data request / write enable, held until dm_gnt
- dm_addr  in  MEM_ADDR_WIDTH;  dm_wr_data  in  DATA_WIDTH
- dm_gnt  out  1  data access accepted this cycle
- dm_rsp_valid  out  1  one-cycle pulse: read data ready or write done
- dm_rsp_data  out  DATA_WIDTH  last load data, held (unchanged by writes)
- mem_en, mem_we  out  1 each;  mem_addr  out  MEM_ADDR_WIDTH;  mem_wr_data  out  DATA_WIDTH
- mem_rd_data  in  DATA_WIDTH  valid MEM_LATENCY cycles after mem_en
- stall_if  out  1  if_req & ~if_gnt
- stall_mem  out  1  (dm_req & ~dm_gnt) | (DM access outstanding, response not yet pulsed)

## Operation
- Registers: busy counter cnt (0..MEM_LATENCY), owner (NONE/IF/DM), kill flag, owner_we, starve_cnt, two response data regs, two valid pulse regs.
- Grant window: cnt==0 (idle) or cnt==1 (final cycle of the current access). At most one grant per cycle.
- Arbitration in window: DM only → DM; IF only → IF; both → DM, unless starve_cnt==STARVE_LIMIT → IF.
- starve_cnt: +1 (saturating) on a DM grant while if_req=1; cleared on any IF grant.
- On grant: mem_en=1 same cycle (combinational), mem_addr/mem_we/mem_wr_data from winner (mem_we=0 for IF); cnt←MEM_LATENCY; owner←winner; kill←0 (or if_kill if IF granted).
- Otherwise cnt decrements when nonzero; mem_en=0, mem_we=0.
- Capture when cnt==1: owner IF & ~kill → if_rsp_data←mem_rd_data, if_rsp_valid←1. Owner DM → dm_rsp_valid←1; dm_rsp_data←mem_rd_data only if ~owner_we. Owner IF & kill → nothing.
- if_kill asserted any cycle while owner==IF and cnt≠0 sets kill.
- Simultaneous capture and new grant in the same cycle: both take effect; owner switches at the edge.

## Timing
- Reset (async, rstb=0): cnt=0, owner=NONE, kill=0, starve_cnt=0, both rsp_valid=0, both rsp_data=0; all mem_* outputs 0; gnt/stall follow inputs combinationally with cnt=0.
- Grant at cycle T → mem_en at T → data on mem_rd_data at T+MEM_LATENCY → rsp_valid pulse and rsp_data at T+MEM_LATENCY+1.
- Throughput: one access per MEM_LATENCY cycles (next grant allowed at T+MEM_LATENCY).
- Reset mid-access: outstanding access dropped, no response pulse after reset release.
- if_gnt, dm_gnt, mem_* and stall_* are combinational from state and requests; rsp_* are registered.

## Structure
- Package pp_mem_pkg: owner enum (OWN_NONE, OWN_IF, OWN_DM), MEM_ADDR_WIDTH default, latency counter width constant.
- One sub-module, mem_arb_timer: cnt, owner, kill, capture strobe; arbitration and response registers stay in the top.

## Test plan
- IF-only read, MEM_LATENCY=2, if_addr=0x10, memory returns 0x2402000A at T+2 → if_gnt at T, if_rsp_valid at T+3, if_rsp_data=0x2402000A, stall_if=0 throughout.
- IF and DM request at T (DM load 0x40 → 0xDEADBEEF) → dm_gnt at T, stall_if=1 T..T+1, if_gnt at T+2, dm_rsp_valid at T+3, if_rsp_valid at T+5.
- DM requesting continuously, IF requesting, STARVE_LIMIT=4 → four DM grants, fifth window grants IF, starve_cnt returns 0.
- DM write addr 0x44 data 0x12345678 → mem_we=1 at grant, dm_rsp_valid at T+3, dm_rsp_data unchanged.
- IF fetch granted at T, if_kill at T+1 → no if_rsp_valid, if_rsp_data keeps old value, next grant still at T+2.
- rstb low at T+1 of an access → all outputs at reset values, no rsp pulse after release, new request granted immediately.
